// File: rtl/cpu_control_id_ex.sv
// LEGv8 ID-stage control decode plus ID/EX pipeline register and EX-stage ALU control.
// Latency: decode is combinational, the ID/EX register adds one cycle. No backpressure; flush inserts a bubble.
module cpu_control_id_ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [10:0] opcode,
    input  logic [63:0] currPC,
    input  logic [63:0] pc_plus4,
    input  logic [63:0] rd1,
    input  logic [63:0] rd2,
    input  logic [63:0] ext_out,
    input  logic [4:0]  targetReg,
    input  logic [5:0]  shamt,
    input  logic        offset_sign,
    output logic        uncondBr,
    output logic        branch,
    output logic        branchReg,
    output logic        Reg2Loc,
    output logic        branchLink,
    output logic        RegWrite,
    output logic        ALU_Src,
    output logic        ALU_SH,
    output logic        Imm,
    output logic        shiftDirn,
    output logic        ALU_on,
    output logic        set_flags,
    output logic        memToReg,
    output logic        memWrite,
    output logic        memRead,
    output logic        ALU_Src_EX,
    output logic        ALU_SH_EX,
    output logic        Imm_EX,
    output logic        shiftDirn_EX,
    output logic        ALU_on_EX,
    output logic        set_flags_EX,
    output logic        branchReg_EX,
    output logic        branch_EX,
    output logic        uncondBr_EX,
    output logic        memToReg_EX,
    output logic        memWrite_EX,
    output logic        memRead_EX,
    output logic        branchLink_EX,
    output logic        RegWrite_EX,
    output logic [63:0] currPC_reg_EX,
    output logic [63:0] pc_plus4_EX,
    output logic [63:0] rd1_EX,
    output logic [63:0] rd2_EX,
    output logic [63:0] ext_out_EX,
    output logic [4:0]  targetReg_EX,
    output logic [5:0]  shamt_EX,
    output logic [10:0] opcode_EX,
    output logic [2:0]  ALU_cntrl_EX
);

    typedef struct packed {
        logic uncond_br;
        logic branch;
        logic branch_reg;
        logic reg2loc;
        logic branch_link;
        logic reg_write;
        logic alu_src;
        logic alu_sh;
        logic imm;
        logic shift_dirn;
        logic alu_on;
        logic set_flags;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
    } ctrl_t;

    // Reg2Loc only steers the ID-stage register read, so it is not carried into EX.
    typedef struct packed {
        logic        uncond_br;
        logic        branch;
        logic        branch_reg;
        logic        branch_link;
        logic        reg_write;
        logic        alu_src;
        logic        alu_sh;
        logic        imm;
        logic        shift_dirn;
        logic        alu_on;
        logic        set_flags;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic [63:0] pc;
        logic [63:0] pc_plus4;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] ext;
        logic [4:0]  target;
        logic [5:0]  shamt;
        logic [10:0] opcode;
        logic        offset_sign;
    } ex_t;

    ctrl_t      dec;
    ex_t        ex_d;
    ex_t        ex_q;
    logic [2:0] alu_cntrl;

    always_comb begin
        dec = '0;
        if (!rst) begin
            casez (opcode)
                11'b1001000100?: begin // ADDI
                    dec.alu_src   = 1'b1;
                    dec.imm       = 1'b1;
                    dec.alu_on    = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.reg2loc   = 1'b1;
                end
                11'b10101011000, 11'b11101011000: begin // ADDS, SUBS
                    dec.reg2loc   = 1'b1;
                    dec.alu_on    = 1'b1;
                    dec.set_flags = 1'b1;
                    dec.reg_write = 1'b1;
                end
                11'b10001010000, 11'b10101010000, 11'b11001010000: begin // AND, ORR, EOR
                    dec.reg2loc   = 1'b1;
                    dec.alu_on    = 1'b1;
                    dec.reg_write = 1'b1;
                end
                11'b11111000010: begin // LDUR
                    dec.alu_src    = 1'b1;
                    dec.alu_on     = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                end
                11'b11111000000: begin // STUR
                    dec.alu_src   = 1'b1;
                    dec.alu_on    = 1'b1;
                    dec.mem_write = 1'b1;
                end
                11'b11010011011: begin // LSL
                    dec.alu_sh    = 1'b1;
                    dec.reg_write = 1'b1;
                end
                11'b11010011010: begin // LSR
                    dec.alu_sh     = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.shift_dirn = 1'b1;
                end
                11'b000101?????: begin // B
                    dec.uncond_br = 1'b1;
                    dec.branch    = 1'b1;
                end
                11'b100101?????: begin // BL
                    dec.uncond_br   = 1'b1;
                    dec.branch      = 1'b1;
                    dec.branch_link = 1'b1;
                    dec.reg_write   = 1'b1;
                end
                11'b11010110000: dec.branch_reg = 1'b1;       // BR
                11'b01010100???: dec.branch     = 1'b1;       // B.cond
                11'b10110100???: dec.branch     = 1'b1;       // CBZ
                default:         dec            = '0;
            endcase
        end
    end

    assign uncondBr   = dec.uncond_br;
    assign branch     = dec.branch;
    assign branchReg  = dec.branch_reg;
    assign Reg2Loc    = dec.reg2loc;
    assign branchLink = dec.branch_link;
    assign RegWrite   = dec.reg_write;
    assign ALU_Src    = dec.alu_src;
    assign ALU_SH     = dec.alu_sh;
    assign Imm        = dec.imm;
    assign shiftDirn  = dec.shift_dirn;
    assign ALU_on     = dec.alu_on;
    assign set_flags  = dec.set_flags;
    assign memToReg   = dec.mem_to_reg;
    assign memWrite   = dec.mem_write;
    assign memRead    = dec.mem_read;

    always_comb begin
        ex_d = '0;
        if (!rst && !flush) begin
            ex_d.uncond_br   = dec.uncond_br;
            ex_d.branch      = dec.branch;
            ex_d.branch_reg  = dec.branch_reg;
            ex_d.branch_link = dec.branch_link;
            ex_d.reg_write   = dec.reg_write;
            ex_d.alu_src     = dec.alu_src;
            ex_d.alu_sh      = dec.alu_sh;
            ex_d.imm         = dec.imm;
            ex_d.shift_dirn  = dec.shift_dirn;
            ex_d.alu_on      = dec.alu_on;
            ex_d.set_flags   = dec.set_flags;
            ex_d.mem_to_reg  = dec.mem_to_reg;
            ex_d.mem_write   = dec.mem_write;
            ex_d.mem_read    = dec.mem_read;
            ex_d.pc          = currPC;
            ex_d.pc_plus4    = pc_plus4;
            ex_d.rd1         = rd1;
            ex_d.rd2         = rd2;
            ex_d.ext         = ext_out;
            ex_d.target      = targetReg;
            ex_d.shamt       = shamt;
            ex_d.opcode      = opcode;
            ex_d.offset_sign = offset_sign;
        end
    end

    always_ff @(posedge clk) begin
        ex_q <= ex_d;
    end

    // Load/store offsets arrive as a magnitude, so a negative one turns the add into a subtract.
    always_comb begin
        alu_cntrl = 3'b000;
        if (ex_q.alu_on) begin
            casez (ex_q.opcode)
                11'b1001000100?: alu_cntrl = 3'b010;                            // ADDI
                11'b10101011000: alu_cntrl = 3'b010;                            // ADDS
                11'b11101011000: alu_cntrl = 3'b011;                            // SUBS
                11'b10001010000: alu_cntrl = 3'b100;                            // AND
                11'b10101010000: alu_cntrl = 3'b101;                            // ORR
                11'b11001010000: alu_cntrl = 3'b110;                            // EOR
                11'b11111000010,
                11'b11111000000: alu_cntrl = ex_q.offset_sign ? 3'b011 : 3'b010; // LDUR, STUR
                default:         alu_cntrl = 3'b000;
            endcase
        end
    end

    assign ALU_Src_EX    = ex_q.alu_src;
    assign ALU_SH_EX     = ex_q.alu_sh;
    assign Imm_EX        = ex_q.imm;
    assign shiftDirn_EX  = ex_q.shift_dirn;
    assign ALU_on_EX     = ex_q.alu_on;
    assign set_flags_EX  = ex_q.set_flags;
    assign branchReg_EX  = ex_q.branch_reg;
    assign branch_EX     = ex_q.branch;
    assign uncondBr_EX   = ex_q.uncond_br;
    assign memToReg_EX   = ex_q.mem_to_reg;
    assign memWrite_EX   = ex_q.mem_write;
    assign memRead_EX    = ex_q.mem_read;
    assign branchLink_EX = ex_q.branch_link;
    assign RegWrite_EX   = ex_q.reg_write;
    assign currPC_reg_EX = ex_q.pc;
    assign pc_plus4_EX   = ex_q.pc_plus4;
    assign rd1_EX        = ex_q.rd1;
    assign rd2_EX        = ex_q.rd2;
    assign ext_out_EX    = ex_q.ext;
    assign targetReg_EX  = ex_q.target;
    assign shamt_EX      = ex_q.shamt;
    assign opcode_EX     = ex_q.opcode;
    assign ALU_cntrl_EX  = alu_cntrl;

endmodule

// File: tb/tb_cpu_control_id_ex.sv
// Directed plus mixed-stimulus bench for cpu_control_id_ex with a mnemonic-level reference model.
module tb_cpu_control_id_ex;

    logic        clk = 1'b0;
    logic        rst, flush, offset_sign;
    logic [10:0] opcode;
    logic [63:0] currPC, pc_plus4, rd1, rd2, ext_out;
    logic [4:0]  targetReg;
    logic [5:0]  shamt;

    logic uncondBr, branch, branchReg, Reg2Loc, branchLink, RegWrite;
    logic ALU_Src, ALU_SH, Imm, shiftDirn, ALU_on, set_flags, memToReg, memWrite, memRead;
    logic ALU_Src_EX, ALU_SH_EX, Imm_EX, shiftDirn_EX, ALU_on_EX, set_flags_EX, branchReg_EX;
    logic branch_EX, uncondBr_EX, memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX;
    logic [63:0] currPC_reg_EX, pc_plus4_EX, rd1_EX, rd2_EX, ext_out_EX;
    logic [4:0]  targetReg_EX;
    logic [5:0]  shamt_EX;
    logic [10:0] opcode_EX;
    logic [2:0]  ALU_cntrl_EX;

    int total = 0;
    int bad   = 0;

    cpu_control_id_ex dut (
        .clk(clk), .rst(rst), .flush(flush), .opcode(opcode),
        .currPC(currPC), .pc_plus4(pc_plus4), .rd1(rd1), .rd2(rd2), .ext_out(ext_out),
        .targetReg(targetReg), .shamt(shamt), .offset_sign(offset_sign),
        .uncondBr(uncondBr), .branch(branch), .branchReg(branchReg), .Reg2Loc(Reg2Loc),
        .branchLink(branchLink), .RegWrite(RegWrite), .ALU_Src(ALU_Src), .ALU_SH(ALU_SH),
        .Imm(Imm), .shiftDirn(shiftDirn), .ALU_on(ALU_on), .set_flags(set_flags),
        .memToReg(memToReg), .memWrite(memWrite), .memRead(memRead),
        .ALU_Src_EX(ALU_Src_EX), .ALU_SH_EX(ALU_SH_EX), .Imm_EX(Imm_EX),
        .shiftDirn_EX(shiftDirn_EX), .ALU_on_EX(ALU_on_EX), .set_flags_EX(set_flags_EX),
        .branchReg_EX(branchReg_EX), .branch_EX(branch_EX), .uncondBr_EX(uncondBr_EX),
        .memToReg_EX(memToReg_EX), .memWrite_EX(memWrite_EX), .memRead_EX(memRead_EX),
        .branchLink_EX(branchLink_EX), .RegWrite_EX(RegWrite_EX),
        .currPC_reg_EX(currPC_reg_EX), .pc_plus4_EX(pc_plus4_EX), .rd1_EX(rd1_EX),
        .rd2_EX(rd2_EX), .ext_out_EX(ext_out_EX), .targetReg_EX(targetReg_EX),
        .shamt_EX(shamt_EX), .opcode_EX(opcode_EX), .ALU_cntrl_EX(ALU_cntrl_EX)
    );

    always #5 clk = ~clk;

    // One-hot control flags in a fixed order shared by the model and the DUT views below.
    localparam logic [14:0] M_UB = 15'h4000, M_BR = 15'h2000, M_BREG = 15'h1000, M_R2L = 15'h0800;
    localparam logic [14:0] M_BL = 15'h0400, M_RW = 15'h0200, M_AS = 15'h0100, M_SH = 15'h0080;
    localparam logic [14:0] M_IM = 15'h0040, M_SD = 15'h0020, M_ON = 15'h0010, M_SF = 15'h0008;
    localparam logic [14:0] M_M2R = 15'h0004, M_MW = 15'h0002, M_MRD = 15'h0001;

    function automatic logic [14:0] mdl_dec(input logic [10:0] op);
        if (op[10:1] == 10'b1001000100)                     return M_AS | M_IM | M_ON | M_RW | M_R2L;
        if (op == 11'b10101011000 || op == 11'b11101011000) return M_R2L | M_ON | M_SF | M_RW;
        if (op == 11'b10001010000 || op == 11'b10101010000 ||
            op == 11'b11001010000)                          return M_R2L | M_ON | M_RW;
        if (op == 11'b11111000010)                          return M_AS | M_ON | M_MRD | M_M2R | M_RW;
        if (op == 11'b11111000000)                          return M_AS | M_ON | M_MW;
        if (op == 11'b11010011011)                          return M_SH | M_RW;
        if (op == 11'b11010011010)                          return M_SH | M_RW | M_SD;
        if (op[10:5] == 6'b000101)                          return M_UB | M_BR;
        if (op[10:5] == 6'b100101)                          return M_UB | M_BR | M_BL | M_RW;
        if (op == 11'b11010110000)                          return M_BREG;
        if (op[10:3] == 8'b01010100)                        return M_BR;
        if (op[10:3] == 8'b10110100)                        return M_BR;
        return 15'h0;
    endfunction

    function automatic logic [2:0] mdl_alu(input logic [10:0] op, input logic sgn);
        if ((mdl_dec(op) & M_ON) == 15'h0)                  return 3'b000;
        if (op[10:1] == 10'b1001000100)                     return 3'b010;
        if (op == 11'b10101011000)                          return 3'b010;
        if (op == 11'b11101011000)                          return 3'b011;
        if (op == 11'b10001010000)                          return 3'b100;
        if (op == 11'b10101010000)                          return 3'b101;
        if (op == 11'b11001010000)                          return 3'b110;
        if (op == 11'b11111000010 || op == 11'b11111000000) return sgn ? 3'b011 : 3'b010;
        return 3'b000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [14:0] dut_dec, dut_ex;
    assign dut_dec = {uncondBr, branch, branchReg, Reg2Loc, branchLink, RegWrite, ALU_Src, ALU_SH,
                      Imm, shiftDirn, ALU_on, set_flags, memToReg, memWrite, memRead};
    assign dut_ex  = {uncondBr_EX, branch_EX, branchReg_EX, 1'b0, branchLink_EX, RegWrite_EX,
                      ALU_Src_EX, ALU_SH_EX, Imm_EX, shiftDirn_EX, ALU_on_EX, set_flags_EX,
                      memToReg_EX, memWrite_EX, memRead_EX};

    // Expected EX-stage contents, captured from the inputs at each rising edge.
    logic        e_vld = 1'b0;
    logic [14:0] e_ctrl;
    logic [63:0] e_pc, e_pc4, e_rd1, e_rd2, e_ext;
    logic [21:0] e_misc;
    logic [2:0]  e_alu;

    always @(posedge clk) begin
        e_vld <= 1'b1;
        if (rst || flush) begin
            e_ctrl <= '0; e_pc <= '0; e_pc4 <= '0; e_rd1 <= '0; e_rd2 <= '0; e_ext <= '0;
            e_misc <= '0; e_alu <= 3'b000;
        end else begin
            e_ctrl <= mdl_dec(opcode) & ~M_R2L;
            e_pc   <= currPC;  e_pc4 <= pc_plus4; e_rd1 <= rd1; e_rd2 <= rd2; e_ext <= ext_out;
            e_misc <= {targetReg, shamt, opcode};
            e_alu  <= mdl_alu(opcode, offset_sign);
        end
    end

    always @(negedge clk) begin
        if (e_vld) begin
            chk("dec", {49'h0, dut_dec}, {49'h0, rst ? 15'h0 : mdl_dec(opcode)});
            chk("ex_ctrl", {49'h0, dut_ex}, {49'h0, e_ctrl});
            chk("ex_pc", currPC_reg_EX, e_pc);
            chk("ex_pc4", pc_plus4_EX, e_pc4);
            chk("ex_rd1", rd1_EX, e_rd1);
            chk("ex_rd2", rd2_EX, e_rd2);
            chk("ex_ext", ext_out_EX, e_ext);
            chk("ex_misc", {42'h0, targetReg_EX, shamt_EX, opcode_EX}, {42'h0, e_misc});
            chk("ex_alu", {61'h0, ALU_cntrl_EX}, {61'h0, e_alu});
        end
    end

    task automatic drive(input logic [10:0] op, input logic sgn);
        opcode      = op;
        offset_sign = sgn;
        currPC      = {$urandom, $urandom};
        pc_plus4    = currPC + 64'd4;
        rd1         = {$urandom, $urandom};
        rd2         = {$urandom, $urandom};
        ext_out     = {$urandom, $urandom};
        targetReg   = 5'($urandom);
        shamt       = 6'($urandom);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    localparam int NLEG = 16;
    logic [10:0] legal [NLEG] = '{
        11'b10010001000, 11'b10010001001, 11'b10101011000, 11'b11101011000,
        11'b10001010000, 11'b10101010000, 11'b11001010000, 11'b11111000010,
        11'b11111000000, 11'b11010011011, 11'b11010011010, 11'b00010110101,
        11'b10010111111, 11'b11010110000, 11'b01010100101, 11'b10110100011};

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(11'b10101011000, 1'b1);
        chk("rst_dec", {49'h0, dut_dec}, 64'h0);
        tick;
        chk("rst_ex", {49'h0, dut_ex}, 64'h0);
        chk("rst_alu", {61'h0, ALU_cntrl_EX}, 64'h0);
        chk("rst_rd1", rd1_EX, 64'h0);
        rst = 1'b0;

        drive(11'b10010001000, 1'b0);
        rd1 = 64'd5; ext_out = 64'd7; #1;
        chk("addi_dec", {61'h0, ALU_Src, Imm, RegWrite}, 64'h7);
        tick;
        chk("addi_src_ex", {63'h0, ALU_Src_EX}, 64'h1);
        chk("addi_rd1_ex", rd1_EX, 64'd5);
        chk("addi_ext_ex", ext_out_EX, 64'd7);
        chk("addi_alu", {61'h0, ALU_cntrl_EX}, 64'h2);

        drive(11'b11111000010, 1'b1);
        tick;
        chk("ldur_ex", {61'h0, memRead_EX, memToReg_EX, RegWrite_EX}, 64'h7);
        chk("ldur_neg_alu", {61'h0, ALU_cntrl_EX}, 64'h3);
        drive(11'b11111000010, 1'b0);
        tick;
        chk("ldur_pos_alu", {61'h0, ALU_cntrl_EX}, 64'h2);

        drive(11'b11111000000, 1'b0);
        chk("stur_dec", {61'h0, Reg2Loc, memWrite, RegWrite}, 64'h2);
        tick;
        drive(11'b11101011000, 1'b0);
        chk("subs_flags", {63'h0, set_flags}, 64'h1);
        tick;
        chk("subs_alu", {61'h0, ALU_cntrl_EX}, 64'h3);

        drive(11'b10010100000, 1'b0);
        chk("bl_dec", {60'h0, uncondBr, branch, branchLink, RegWrite}, 64'hF);
        tick;
        drive(11'b10110100000, 1'b0);
        chk("cbz_dec", {61'h0, branch, uncondBr, Reg2Loc}, 64'h4);
        tick;
        drive(11'b11010011010, 1'b0);
        shamt = 6'd3; #1;
        tick;
        chk("lsr_ex", {62'h0, shiftDirn_EX, ALU_SH_EX}, 64'h3);
        chk("lsr_shamt", {58'h0, shamt_EX}, 64'd3);

        drive(11'b10101011000, 1'b0);
        tick;
        chk("adds_alu", {61'h0, ALU_cntrl_EX}, 64'h2);
        flush = 1'b1;
        tick;
        chk("flush_ex", {49'h0, dut_ex}, 64'h0);
        chk("flush_alu", {61'h0, ALU_cntrl_EX}, 64'h0);
        flush = 1'b0;
        drive(11'b00000000000, 1'b1);
        chk("nop_dec", {49'h0, dut_dec}, 64'h0);
        tick;

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 24) == 0);
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0)
                drive(legal[$urandom_range(0, NLEG - 1)], 1'($urandom));
            else
                drive(11'($urandom), 1'($urandom));
            tick;
        end
        rst = 1'b0; flush = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_id_ex.md
Name: cpu_control_id_ex

Overview:
- Decode-and-pipeline block for the 5-stage LEGv8 CPU.
- Combinationally decodes the 11-bit instruction opcode from IF/ID into datapath control signals.
- Registers those controls plus ID-stage operands into the ID/EX pipeline register on the clock edge.
- Derives the 3-bit ALU operation for the EX stage from the registered opcode.

Parameters:
- none; all widths are fixed at 64-bit data, 5-bit register index, 11-bit opcode.

Ports:
- clk  in  1  rising-edge clock for the ID/EX register
- rst  in  1  synchronous, active-high reset
- flush  in  1  on next edge, loads a bubble (all control fields 0) into ID/EX
- opcode  in  11  instruction[31:21] from IF/ID
- currPC, pc_plus4, rd1, rd2, ext_out  in  64 each  ID-stage PC, PC+4, register reads, extended immediate
- targetReg  in  5  destination register
- shamt  in  6  shift amount
- offset_sign  in  1  sign bit of the sign-extended dAddr9
- uncondBr, branch, branchReg, Reg2Loc, branchLink, RegWrite  out  1 each  combinational ID-stage decode
- ALU_Src, ALU_SH, Imm, shiftDirn, ALU_on, set_flags, memToReg, memWrite, memRead  out  1 each  combinational decode
- ALU_Src_EX, ALU_SH_EX, Imm_EX, shiftDirn_EX, ALU_on_EX, set_flags_EX, branchReg_EX, branch_EX, uncondBr_EX, memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX  out  1 each  registered controls
- currPC_reg_EX, pc_plus4_EX, rd1_EX, rd2_EX, ext_out_EX  out  64 each  registered data
- targetReg_EX  out  5;  shamt_EX  out  6;  opcode_EX  out  11
- ALU_cntrl_EX  out  3  combinational from EX-stage registered state

Behaviour:
- Decode is purely combinational. While rst=1, every decode output is forced to 0.
- Any opcode not listed below decodes to all-zero controls (NOP).
- Decode table; every signal not named is 0:
  - ADDI (opcode[10:1]=1001000100): ALU_Src, Imm, ALU_on, RegWrite, Reg2Loc.
  - ADDS 10101011000 / SUBS 11101011000: Reg2Loc, ALU_on, set_flags, RegWrite.
  - AND 10001010000 / ORR 10101010000 / EOR 11001010000: Reg2Loc, ALU_on, RegWrite.
  - LDUR 11111000010: ALU_Src, ALU_on, memRead, memToReg, RegWrite.
  - STUR 11111000000: ALU_Src, ALU_on, memWrite; Reg2Loc=0.
  - LSL 11010011011: ALU_SH, RegWrite, shiftDirn=0.
  - LSR 11010011010: ALU_SH, RegWrite, shiftDirn=1.
  - B (opcode[10:5]=000101): uncondBr, branch.
  - BL (opcode[10:5]=100101): uncondBr, branch, branchLink, RegWrite.
  - BR 11010110000: branchReg; Reg2Loc=0.
  - B.cond (opcode[10:3]=01010100): branch; Reg2Loc=0.
  - CBZ (opcode[10:3]=10110100): branch; Reg2Loc=0.
- ID/EX register: all *_EX outputs update on the rising clk edge, 1-cycle latency, no enable.
- rst=1 or flush=1 at an edge: every *_EX output becomes 0.
- rst has priority over flush; flush has priority over normal load.
- offset_sign is captured internally alongside opcode_EX.
- ALU_cntrl_EX encoding: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
  - ALU_on_EX=0: 000.
  - ADDI/ADDS: 010. SUBS: 011. AND: 100. ORR: 101. EOR: 110.
  - LDUR/STUR: 011 if the registered offset_sign=1, else 010. A negative offset arrives as a magnitude, so it is subtracted.
  - Any other opcode with ALU_on_EX=1: 000.
- After reset, the EX stage shows a bubble: all outputs 0 and ALU_cntrl_EX=000.

Test Plan:
- rst=1 for one edge with arbitrary opcode and data inputs -> all *_EX outputs 0, ALU_cntrl_EX=000, and all decode outputs 0 while rst is high.
- ADDI opcode 10010001000, rd1=5, ext_out=7 -> ALU_Src=Imm=RegWrite=1 combinationally; after one edge ALU_Src_EX=1, rd1_EX=5, ext_out_EX=7, ALU_cntrl_EX=010.
- LDUR 11111000010 with offset_sign=1 -> after one edge memRead_EX=memToReg_EX=RegWrite_EX=1, ALU_cntrl_EX=011; repeat with offset_sign=0 -> 010.
- STUR 11111000000 -> Reg2Loc=0, memWrite=1, RegWrite=0; SUBS 11101011000 -> set_flags=1 and, one cycle later, ALU_cntrl_EX=011.
- BL 10010100000 -> uncondBr=branch=branchLink=RegWrite=1; CBZ 10110100000 -> branch=1, uncondBr=0, Reg2Loc=0; LSR 11010011010 with shamt=3 -> shiftDirn_EX=1, ALU_SH_EX=1, shamt_EX=3.
- Load ADDS, then assert flush with ADDS still on opcode -> next edge all *_EX controls 0; illegal opcode 00000000000 -> all decode outputs 0.
